// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - UART transmitter with transmit FIFO and baud-tick driven framing
//
// Purpose:
//   Queues words in a small FIFO and serialises them as UART frames:
//   start bit, DATA_W data bits LSB first, optional parity bit, and
//   STOP_BITS stop bits. Every bit interval spans from one clk_en_i tick
//   to the next. Back-to-back frames are sent with no idle gap.
//
// Optional feature (macro UART_TX_BREAK_EN):
//   Adds break_i. While break_i is high the line is held low, the FSM freezes
//   and nothing is popped. After release the FSM returns to IDLE on the next
//   tick. The in-flight frame is dropped; queued words stay queued.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
//   PARITY_MODE 0 = none, 1 = even, 2 = odd
//   STOP_BITS   stop bits per frame (1 or 2)
//   DEPTH       FIFO entries, power of 2 (2..64)
//
// Ports:
//   clk_i         clock, rising edge
//   resetn_i      synchronous active-low reset
//   clk_en_i      one-cycle baud tick
//   datain_i      word to queue
//   shoot_i       push request
//   break_i       line break request (only with UART_TX_BREAK_EN)
//   uart_tx_o     registered serial line, idle high
//   uart_busy_o   FSM not idle or FIFO non-empty
//   fifo_full_o   FIFO count equals DEPTH
//   fifo_level_o  current FIFO count
//   overflow_o    one-cycle pulse after a push was dropped

module uart_tx_gen #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       clk_en_i,
  input  logic [DATA_W-1:0]          datain_i,
  input  logic                       shoot_i,
`ifdef UART_TX_BREAK_EN
  input  logic                       break_i,
`endif
  output logic                       uart_tx_o,
  output logic                       uart_busy_o,
  output logic                       fifo_full_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
  output logic                       overflow_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              overflow_q;
  logic [DATA_W-1:0] head;

  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Acceptance looks only at the registered count, so a pop in the same
  // cycle does not make room for a push that arrives while full.
  assign push = shoot_i && !full;

  // Storage carries no reset: its content is only observable through
  // rd_ptr/count, which are reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= datain_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow_q <= shoot_i && full;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [BIT_W-1:0]  bit_q;
  logic [BIT_W-1:0]  bit_d;
  logic [BIT_W-1:0]  bit_nxt;
  logic              stop_q;
  logic              stop_d;
  logic              tx_q;
  logic              tx_d;
  logic              par_bit;
  logic              last_stop;

`ifdef UART_TX_BREAK_EN
  logic              brk_pend_q;
  logic              brk_pend_d;
`endif

  // Mode 1 makes the total number of ones even, mode 2 makes it odd.
  assign par_bit   = (PARITY_MODE == 2) ? ~(^data_q) : (^data_q);
  assign last_stop = (STOP_BITS == 1) || stop_q;
  assign bit_nxt   = bit_q + 1'b1;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_pend_d = brk_pend_q;
    if (break_i) begin
      // Freeze everything and hold the line low.
      tx_d       = 1'b0;
      brk_pend_d = 1'b1;
    end else if (brk_pend_q) begin
      // Break released: line idles high until the next tick resets the FSM.
      tx_d = 1'b1;
      if (clk_en_i) begin
        state_d    = S_IDLE;
        brk_pend_d = 1'b0;
      end
    end else begin
`endif
    if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
        S_DATA: begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            if (PARITY_MODE != 0) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          if (last_stop) begin
            // Chain straight into the next start bit when more data waits.
            if (!empty) begin
              pop     = 1'b1;
              data_d  = head;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
`ifdef UART_TX_BREAK_EN
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      brk_pend_q <= 1'b0;
    end else begin
      brk_pend_q <= brk_pend_d;
    end
  end
`endif

  assign uart_tx_o    = tx_q;
  assign uart_busy_o  = (state_q != S_IDLE) || !empty;
  assign fifo_full_o  = full;
  assign fifo_level_o = count;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb/tb_uart_tx_gen.sv - directed self-checking bench for uart_tx_gen
//
// Four instances share stimulus: [0] even parity/1 stop, [1] odd parity,
// [2] no parity, [3] even parity/2 stops. Line values are sampled after
// each baud tick, away from the clock edge.

module tb_uart_tx_gen;

  logic       clk;
  logic       resetn;
  logic       clk_en;
  logic [7:0] datain;
  logic       shoot;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  logic       tx   [4];
  logic       busy [4];
  logic       full [4];
  logic [2:0] lvl  [4];
  logic       ovf  [4];

  int n_vec;
  int n_err;

  logic exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_gen #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .DEPTH(4)) dut_p1 (
    .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_i(datain), .shoot_i(shoot),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .uart_tx_o(tx[0]), .uart_busy_o(busy[0]), .fifo_full_o(full[0]),
    .fifo_level_o(lvl[0]), .overflow_o(ovf[0]));

  uart_tx_gen #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(1), .DEPTH(4)) dut_p2 (
    .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_i(datain), .shoot_i(shoot),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .uart_tx_o(tx[1]), .uart_busy_o(busy[1]), .fifo_full_o(full[1]),
    .fifo_level_o(lvl[1]), .overflow_o(ovf[1]));

  uart_tx_gen #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(1), .DEPTH(4)) dut_p0 (
    .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_i(datain), .shoot_i(shoot),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .uart_tx_o(tx[2]), .uart_busy_o(busy[2]), .fifo_full_o(full[2]),
    .fifo_level_o(lvl[2]), .overflow_o(ovf[2]));

  uart_tx_gen #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(2), .DEPTH(4)) dut_s2 (
    .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_i(datain), .shoot_i(shoot),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .uart_tx_o(tx[3]), .uart_busy_o(busy[3]), .fifo_full_o(full[3]),
    .fifo_level_o(lvl[3]), .overflow_o(ovf[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One baud tick followed by three idle cycles.
  task automatic tick();
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    shoot  = 1'b0;
    clk_en = 1'b0;
    datain = 8'h00;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] w);
    shoot  = 1'b1;
    datain = w;
    step();
    shoot  = 1'b0;
  endtask

  // Expected serial bits of one 8-bit frame.
  task automatic add_frame(input logic [7:0] w, input int pmode, input int nstop);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (pmode == 1) exp_q.push_back(^w);
    if (pmode == 2) exp_q.push_back(~(^w));
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({tx[0], busy[0], full[0], lvl[0], ovf[0]} !== 7'b1_0_0_000_0) begin
      n_err++;
      $display("FAIL reset_state: got tx/busy/full/lvl/ovf=%b %b %b %0d %b, want 1 0 0 0 0",
               tx[0], busy[0], full[0], lvl[0], ovf[0]);
    end
  endtask

  // 0x4F on all four parameter sets, 13 ticks each.
  task automatic test_frame_formats();
    logic [0:12] exp_line [4];
    logic [0:12] exp_busy [4];
    exp_line[0] = 13'b0111100101111;
    exp_line[1] = 13'b0111100100111;
    exp_line[2] = 13'b0111100101111;
    exp_line[3] = 13'b0111100101111;
    exp_busy[0] = 13'b1111111111100;
    exp_busy[1] = 13'b1111111111100;
    exp_busy[2] = 13'b1111111111000;
    exp_busy[3] = 13'b1111111111110;
    do_reset();
    push_word(8'h4F);
    for (int t = 0; t < 13; t++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        n_vec++;
        if (tx[d] !== exp_line[d][t] || busy[d] !== exp_busy[d][t]) begin
          n_err++;
          $display("FAIL frame_dut%0d_tick%0d: got line=%b busy=%b, want line=%b busy=%b",
                   d, t + 1, tx[d], busy[d], exp_line[d][t], exp_busy[d][t]);
        end
      end
    end
  endtask

  task automatic test_fifo_overflow();
    logic bad_ovf;
    logic bad_full;
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) add_frame(8'(i), 1, 1);
    bad_ovf  = 1'b0;
    bad_full = 1'b0;
    shoot = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      datain = 8'(i);
      clk_en = (i == 2);
      step();
      if (ovf[0]) bad_ovf = 1'b1;
      if (i <= 4 && full[0]) bad_full = 1'b1;
      if (i == 2) begin
        n_vec++;
        if (tx[0] !== exp_q[0]) begin
          n_err++;
          $display("FAIL fifo_first_pop: got line=%b, want %b", tx[0], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    clk_en = 1'b0;
    n_vec++;
    if (bad_ovf !== 1'b0 || bad_full !== 1'b0 || lvl[0] !== 3'd4) begin
      n_err++;
      $display("FAIL fifo_fill: got ovf_seen=%b early_full=%b level=%0d, want 0 0 4",
               bad_ovf, bad_full, lvl[0]);
    end
    datain = 8'h06;
    step();
    shoot = 1'b0;
    n_vec++;
    if (full[0] !== 1'b1 || ovf[0] !== 1'b1 || lvl[0] !== 3'd4) begin
      n_err++;
      $display("FAIL fifo_overflow_pulse: got full=%b ovf=%b level=%0d, want 1 1 4",
               full[0], ovf[0], lvl[0]);
    end
    step();
    n_vec++;
    if (ovf[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_overflow_width: got ovf=%b, want 0", ovf[0]);
    end
    for (int t = 0; exp_q.size() > 0; t++) begin
      logic e;
      e = exp_q.pop_front();
      tick();
      n_vec++;
      if (tx[0] !== e) begin
        n_err++;
        $display("FAIL fifo_stream_tick%0d: got line=%b, want %b", t, tx[0], e);
      end
    end
    repeat (3) tick();
    n_vec++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || lvl[0] !== 3'd0) begin
      n_err++;
      $display("FAIL fifo_extra_word: got line=%b busy=%b level=%0d, want 1 0 0",
               tx[0], busy[0], lvl[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    add_frame(8'hA5, 1, 2);
    add_frame(8'h3C, 1, 2);
    exp_q.push_back(1'b1);
    push_word(8'hA5);
    push_word(8'h3C);
    for (int t = 0; exp_q.size() > 0; t++) begin
      logic e;
      e = exp_q.pop_front();
      tick();
      n_vec++;
      if (tx[3] !== e) begin
        n_err++;
        $display("FAIL b2b_stop2_tick%0d: got line=%b, want %b", t, tx[3], e);
      end
    end
    n_vec++;
    if (busy[3] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_busy: got %b, want 0", busy[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic seen_low;
    do_reset();
    push_word(8'h47);
    push_word(8'h55);
    repeat (5) tick();
    n_vec++;
    if (tx[0] !== 1'b0 || lvl[0] !== 3'd1) begin
      n_err++;
      $display("FAIL midreset_bit3: got line=%b level=%0d, want 0 1", tx[0], lvl[0]);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_vec++;
    if (tx[0] !== 1'b1 || lvl[0] !== 3'd0 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_abort: got line=%b level=%0d busy=%b, want 1 0 0",
               tx[0], lvl[0], busy[0]);
    end
    seen_low = 1'b0;
    repeat (15) begin
      clk_en = 1'b1;
      step();
      if (tx[0] !== 1'b1) seen_low = 1'b1;
      clk_en = 1'b0;
      repeat (3) begin
        step();
        if (tx[0] !== 1'b1) seen_low = 1'b1;
      end
    end
    n_vec++;
    if (seen_low !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_resume: got line low after reset, want steady 1");
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic seen_high;
    do_reset();
    push_word(8'h4F);
    push_word(8'h33);
    repeat (3) tick();
    brk = 1'b1;
    step();
    seen_high = 1'b0;
    repeat (20) begin
      clk_en = 1'b1;
      step();
      if (tx[0] !== 1'b0) seen_high = 1'b1;
      clk_en = 1'b0;
      repeat (3) begin
        step();
        if (tx[0] !== 1'b0) seen_high = 1'b1;
      end
    end
    n_vec++;
    if (seen_high !== 1'b0 || lvl[0] !== 3'd1) begin
      n_err++;
      $display("FAIL break_hold: got high_seen=%b level=%0d, want 0 1", seen_high, lvl[0]);
    end
    brk = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(8'h33, 1, 1);
    exp_q.push_back(1'b1);
    for (int t = 0; exp_q.size() > 0; t++) begin
      logic e;
      e = exp_q.pop_front();
      tick();
      n_vec++;
      if (tx[0] !== e) begin
        n_err++;
        $display("FAIL break_resume_tick%0d: got line=%b, want %b", t, tx[0], e);
      end
    end
    n_vec++;
    if (busy[0] !== 1'b0 || lvl[0] !== 3'd0) begin
      n_err++;
      $display("FAIL break_end: got busy=%b level=%0d, want 0 0", busy[0], lvl[0]);
    end
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    clk_en = 1'b0;
    shoot  = 1'b0;
    datain = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk    = 1'b0;
`endif
    test_reset();
    test_frame_formats();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
